// File: rtl/uart_rx_amisha.sv
// 8N1 UART receiver with 16x oversampling, fed by an external mod-m tick strobe.
// A 2-FF synchronizer guards rx_amisha; all decisions use the synchronized line.
module uart_rx_amisha #(
  parameter int DBIT_amisha    = 8,
  parameter int SB_TICK_amisha = 16
) (
  input  logic                   clk_amisha,
  input  logic                   reset_amisha,
  input  logic                   rx_amisha,
  input  logic                   s_tick_amisha,
  output logic                   rx_done_tick_amisha,
  output logic [DBIT_amisha-1:0] dout_amisha,
  output logic                   frame_err_amisha,
  output logic [1:0]             state_dbg_o
);

  // Output handshake: rx_done_tick_amisha is a one-cycle valid with no ready;
  // dout_amisha is valid in that cycle and holds until the next completed frame.

  localparam int SW = ($clog2(SB_TICK_amisha) > 4) ? $clog2(SB_TICK_amisha) : 4;
  localparam int NW = (DBIT_amisha > 1) ? $clog2(DBIT_amisha) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_LAST = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK_amisha - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT_amisha - 1);

  logic                   sync1_q, sync2_q;
  logic                   rx_s;
  logic [1:0]             state_q, state_d;
  logic [SW-1:0]          s_q, s_d;
  logic [NW-1:0]          n_q, n_d;
  logic [DBIT_amisha-1:0] b_q, b_d;
  logic [DBIT_amisha-1:0] dout_q, dout_d;
  logic                   done_q, done_d;
  logic                   ferr_q, ferr_d;

  assign rx_s = sync2_q;

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_amisha;
      sync2_q <= sync1_q;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      // Start detection is not tick-gated so the edge is seen as early as possible.
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick_amisha) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick_amisha) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT_amisha-1:1]};
            if (n_q == N_LAST) state_d = STOP;
            else               n_d = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick_amisha) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            dout_d  = b_q;
            done_d  = 1'b1;
            ferr_d  = ~rx_s;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_done_tick_amisha = done_q;
  assign frame_err_amisha    = ferr_q;
  assign dout_amisha         = dout_q;
  assign state_dbg_o         = state_q;

endmodule

// File: tb/tb_uart_rx_amisha.sv
// Directed bench for uart_rx_amisha: two instances (1 and 2 stop bits) share one line.
// A single driver process steps the clock, presents ticks and records done pulses.
module tb_uart_rx_amisha;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       tick = 1'b0;
  logic       done16, ferr16, done32, ferr32;
  logic [7:0] dout16, dout32;
  logic [1:0] st16, st32;

  int tests = 0;
  int fails = 0;
  int tick_m = 8;
  int tick_cnt = 0;
  int tick_total = 0;
  int stamp16 = 0;
  int stamp32 = 0;
  int stray = 0;
  int edge_stamp = 0;
  int lat;

  logic [7:0] exp_q[$];
  logic [7:0] got16_q[$];
  logic       err16_q[$];
  logic [7:0] got32_q[$];
  logic       err32_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  uart_rx_amisha #(.DBIT_amisha(8), .SB_TICK_amisha(16)) dut16 (
    .clk_amisha(clk), .reset_amisha(rst), .rx_amisha(rx), .s_tick_amisha(tick),
    .rx_done_tick_amisha(done16), .dout_amisha(dout16), .frame_err_amisha(ferr16),
    .state_dbg_o(st16)
  );

  uart_rx_amisha #(.DBIT_amisha(8), .SB_TICK_amisha(32)) dut32 (
    .clk_amisha(clk), .reset_amisha(rst), .rx_amisha(rx), .s_tick_amisha(tick),
    .rx_done_tick_amisha(done32), .dout_amisha(dout32), .frame_err_amisha(ferr32),
    .state_dbg_o(st32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, then update the tick strobe.
  task automatic step();
    @(negedge clk);
    if (done16) begin
      got16_q.push_back(dout16);
      err16_q.push_back(ferr16);
      stamp16 = tick_total;
    end
    if (done32) begin
      got32_q.push_back(dout32);
      err32_q.push_back(ferr32);
      stamp32 = tick_total;
    end
    if (ferr16 && !done16) stray++;
    if (ferr32 && !done32) stray++;
    tick_cnt++;
    if (tick_cnt >= tick_m) begin
      tick_cnt = 0;
      tick = 1'b1;
      tick_total++;
    end else begin
      tick = 1'b0;
    end
  endtask

  task automatic send_ticks(input logic bitv, input int n);
    rx = bitv;
    repeat (n) begin
      do step(); while (!tick);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_ticks, input logic stop_val);
    exp_q.push_back(b);
    edge_stamp = tick_total;
    send_ticks(1'b0, 16);
    for (int k = 0; k < 8; k++) send_ticks(b[k], 16);
    send_ticks(stop_val, stop_ticks);
    rx = 1'b1;
  endtask

  task automatic clear_all();
    exp_q.delete();
    got16_q.delete();
    err16_q.delete();
    got32_q.delete();
    err32_q.delete();
  endtask

  // Scoreboard: compare received bytes of the 1-stop-bit instance with expectations.
  task automatic check_frames(input string tag, input int n, input logic exp_err);
    check({tag, "_count"}, got16_q.size(), n);
    while (exp_q.size() > 0 && got16_q.size() > 0) begin
      check({tag, "_dout"}, got16_q.pop_front(), exp_q.pop_front());
      check({tag, "_ferr"}, err16_q.pop_front(), exp_err);
    end
    clear_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    // reset state
    rx = 1'b1;
    repeat (4) step();
    check("rst_done", done16, 0);
    check("rst_ferr", ferr16, 0);
    check("rst_dout", dout16, 8'h00);
    check("rst_state", st16, 2'd0);
    check("rst_dout32", dout32, 8'h00);
    rst = 1'b0;
    repeat (4) step();

    // single byte with latency check
    clear_all();
    send_byte(8'hA5, 16, 1'b1);
    send_ticks(1'b1, 20);
    lat = stamp16 - edge_stamp;
    check("single_lat_ok", (lat >= 151 && lat <= 153), 1);
    check_frames("single", 1, 1'b0);

    // back-to-back bytes, no idle gap
    send_byte(8'h00, 16, 1'b1);
    send_byte(8'hFF, 16, 1'b1);
    send_byte(8'h3C, 16, 1'b1);
    send_ticks(1'b1, 20);
    check_frames("b2b", 3, 1'b0);

    // start glitch, then a real frame
    send_ticks(1'b0, 4);
    send_ticks(1'b1, 20);
    check("glitch_count", got16_q.size(), 0);
    check("glitch_state", st16, 2'd0);
    clear_all();
    send_byte(8'h81, 16, 1'b1);
    send_ticks(1'b1, 20);
    check_frames("after_glitch", 1, 1'b0);

    // framing error: the stop bit stays low past the receiver's stop sample point,
    // then rises early enough that the receiver rejects it as a glitch start.
    send_byte(8'h55, 12, 1'b0);
    send_ticks(1'b1, 30);
    check_frames("frame_err", 1, 1'b1);

    // reset mid-DATA with a slow M = 163 tick
    tick_m = 163;
    tick_cnt = 0;
    send_ticks(1'b0, 16);
    send_ticks(1'b1, 16);
    send_ticks(1'b0, 8);
    check("pre_rst_state", st16, 2'd2);
    rst = 1'b1;
    step();
    check("mid_rst_done", done16, 0);
    check("mid_rst_ferr", ferr16, 0);
    check("mid_rst_dout", dout16, 8'h00);
    check("mid_rst_state", st16, 2'd0);
    rx = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    send_ticks(1'b1, 20);
    check("post_rst_count", got16_q.size(), 0);
    clear_all();
    tick_m = 8;
    tick_cnt = 0;
    send_byte(8'h96, 16, 1'b1);
    send_ticks(1'b1, 20);
    check_frames("post_rst", 1, 1'b0);

    // two stop bits on the SB_TICK = 32 instance
    do_reset();
    clear_all();
    send_byte(8'hC3, 32, 1'b1);
    send_ticks(1'b1, 20);
    lat = stamp32 - edge_stamp;
    check("sb32_count", got32_q.size(), 1);
    if (got32_q.size() > 0) begin
      check("sb32_dout", got32_q[0], 8'hC3);
      check("sb32_ferr", err32_q[0], 0);
    end
    check("sb32_lat_ok", (lat >= 167 && lat <= 169), 1);

    check("stray_ferr", stray, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_amisha.md
# uart_rx_amisha

Asynchronous serial receiver that converts an 8N1 line into parallel bytes using 16x oversampling. It sits directly downstream of the mod-m counter. That counter's max_tick output, configured for 16 × baud rate (for example M = 163 at 50 MHz for 19200 baud), drives s_tick_amisha. Each received byte is presented on dout_amisha together with a one-cycle completion pulse, for a downstream FIFO or interface block.

## Interface
- DBIT_amisha, 8: number of data bits per frame, LSB first.
- SB_TICK_amisha, 16: oversampling ticks per stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- clk_amisha  input  1  system clock; all logic on its rising edge.
- reset_amisha  input  1  asynchronous, active-high reset.
- rx_amisha  input  1  serial line; idles high; asynchronous to clk_amisha.
- s_tick_amisha  input  1  oversampling strobe; one clk_amisha cycle wide, 16 per bit period.
- rx_done_tick_amisha  output  1  one-cycle pulse: frame complete, dout_amisha valid.
- dout_amisha  output  DBIT_amisha  last received data word; held until the next completed frame.
- frame_err_amisha  output  1  one-cycle pulse coincident with rx_done_tick_amisha when the stop bit sampled low.

## Operation
- **Input synchronizer.** rx_amisha passes through a 2-FF synchronizer. Both flops reset to 1. All decisions use the synchronized value rx_s.
- **Registers.**
  - state: IDLE, START, DATA or STOP.
  - s_reg: tick counter, 4 bits minimum, wide enough for SB_TICK_amisha-1.
  - n_reg: bit counter, ceil(log2(DBIT_amisha)) bits.
  - b_reg: DBIT_amisha-bit shift register.
  - dout register.
- **IDLE.** When rx_s = 0 (checked every clock, not gated by tick): go to START and clear s_reg to 0.
- **START.** Act only on s_tick_amisha = 1.
  - If s_reg = 7 (mid start bit) and rx_s = 0: go to DATA, clear s_reg and n_reg.
  - If s_reg = 7 and rx_s = 1: treat as a glitch and return to IDLE with no output.
  - Otherwise increment s_reg.
- **DATA.** Act only on tick.
  - If s_reg = 15: clear s_reg and shift right, b_reg <= {rx_s, b_reg[DBIT-1:1]}. If n_reg = DBIT_amisha-1 go to STOP, else increment n_reg.
  - Otherwise increment s_reg.
- **STOP.** Act only on tick.
  - If s_reg = SB_TICK_amisha-1: go to IDLE, dout <= b_reg, pulse rx_done_tick_amisha, and pulse frame_err_amisha if rx_s = 0.
  - Otherwise increment s_reg.
- **Error frames.** On a framing error the data is still delivered. The consumer decides whether to discard it.
- **Tick independence.** Clock cycles with s_tick_amisha = 0 never change s_reg, n_reg or b_reg.
- **Back-to-back frames.** A start edge is accepted in the cycle after the return to IDLE. No extra idle time is required beyond the stop bit.

## Timing
- **Reset values.**
  - state = IDLE; s_reg = 0; n_reg = 0; b_reg = 0.
  - dout_amisha = 0; rx_done_tick_amisha = 0; frame_err_amisha = 0.
  - Synchronizer flops = 1.
- **Reset mid-frame.** The frame is abandoned immediately and no done pulse is produced. After reset release, a line still low is seen as a new start bit.
- **Done pulse timing.** rx_done_tick_amisha and frame_err_amisha are registered. They are high for exactly one clk_amisha cycle, the cycle after the final stop-bit tick is consumed.
- **dout_amisha timing.** dout_amisha changes in the same cycle the done pulse rises.
- **Sampling points.** Data bit k is sampled at tick 8 + 16·(k+1) after the start edge is detected, i.e. mid-bit.
- **Frame latency.** From the synchronized falling edge to rx_done_tick_amisha: 8 + 16·DBIT_amisha + SB_TICK_amisha ticks, plus 1 clk. With defaults this is 152 ticks.
- **Synchronizer latency.** The synchronizer adds 2 clk of latency on rx_amisha.
- **Tick limit.** s_tick_amisha must not be high for two consecutive cycles. Behaviour in that case is unspecified.

## Test plan
- **Reset.** Assert reset_amisha mid-DATA, with s_tick from a mod-m counter at M = 163 -> all outputs 0, state IDLE. After release, no rx_done_tick_amisha until a full new frame is received.
- **Single byte.** Send 0xA5, 8N1, 16 ticks per bit -> one rx_done_tick_amisha pulse, dout_amisha = 0xA5, frame_err_amisha = 0. Pulse arrives 152 ticks (±1 tick) after the start edge.
- **Back-to-back bytes.** Send 0x00, 0xFF, 0x3C with no idle gap -> three done pulses, dout_amisha sequence 0x00, 0xFF, 0x3C, no errors.
- **Start glitch.** Drive rx_amisha low for 4 ticks, then high -> return to IDLE, no done pulse. A following 0x81 frame is received correctly.
- **Framing error.** Send 0x55 with the stop bit held low -> rx_done_tick_amisha and frame_err_amisha both pulse in the same cycle, dout_amisha = 0x55.
- **Stop-bit parameter.** With SB_TICK_amisha = 32, send 0xC3 -> done pulse arrives 168 ticks after the start edge, dout_amisha = 0xC3.
